conv_img_line_feeder: RTL and testbench

Producer for the 2D convolution datapath's image port. It accepts a raster-order pixel stream with all IMG_D channels of one pixel per beat, keeps the last FILTER_L image rows in a circular line buffer, and emits one FILTER_L-tall column per channel per accepted pixel. Each column comes with the rotation offset, shift-enable and result write address that the datapath consumes. It also holds off the next frame until the datapath reports its last result write.

---
 rtl/conv_img_line_feeder_if.sv | 22 ++
 rtl/conv_img_line_feeder.sv | 201 ++++++++++++++++++++
 tb/tb_conv_img_line_feeder.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_img_line_feeder_if.sv
// Pixel-stream handshake into the line feeder.
// One beat carries every channel of a single pixel.
interface conv_img_line_feeder_if #(
  parameter int DATA_WIDTH = 12,
  parameter int IMG_D      = 32
);
  logic [DATA_WIDTH*IMG_D-1:0] in_data;
  logic                        in_valid;
  logic                        in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/conv_img_line_feeder.sv
// Line-buffered column producer for the conv datapath image port.
// Holds FILTER_L rows and emits one window column per accepted pixel.
module conv_img_line_feeder #(
  parameter int DATA_WIDTH = 12,
  parameter int IMG_W      = 16,
  parameter int IMG_H      = 16,
  parameter int IMG_D      = 32,
  parameter int FILTER_L   = 3,
  parameter int RESULT_W   = (IMG_W-FILTER_L)+1,
  parameter int RESULT_H   = (IMG_H-FILTER_L)+1,
  parameter int FILTER_L_ADDR_WIDTH =
    $clog2(FILTER_L),
  parameter int RESULT_RAM_ADDR_WIDTH =
    $clog2(RESULT_W*RESULT_H)
) (
  input  logic clk,
  input  logic reset,
  conv_img_line_feeder_if.slave pix,
  output logic [DATA_WIDTH*IMG_D*FILTER_L-1:0]
               img_data_in,
  output logic dpath_wren,
  output logic dpath_sum_en,
  output logic [FILTER_L_ADDR_WIDTH-1:0]
               dpath_rotation_offset,
  output logic [RESULT_RAM_ADDR_WIDTH-1:0]
               dpath_result_wraddr,
  input  logic last_val,
  output logic frame_done
);

  localparam int PIX_W = DATA_WIDTH*IMG_D;
  localparam int COL_W = PIX_W*FILTER_L;
  localparam int W_W   =
    (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int H_W   =
    (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int FA_W  = FILTER_L_ADDR_WIDTH;
  localparam int RA_W  = RESULT_RAM_ADDR_WIDTH;

  localparam logic [W_W-1:0] W_LAST =
    W_W'(IMG_W-1);
  localparam logic [H_W-1:0] H_LAST =
    H_W'(IMG_H-1);
  localparam logic [W_W-1:0] W_EMIT =
    W_W'(FILTER_L-1);
  localparam logic [H_W-1:0] H_EMIT =
    H_W'(FILTER_L-1);
  localparam logic [FA_W-1:0] HM_LAST =
    FA_W'(FILTER_L-1);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic [W_W-1:0]    w_q, w_d;
  logic [H_W-1:0]    h_q, h_d;
  logic [FA_W-1:0]   hm_q, hm_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              wren_q, wren_d;
  logic [FA_W-1:0]   off_q, off_d;
  logic [RA_W-1:0]   addr_q, addr_d;
  logic              done_q, done_d;

  logic              accept;
  logic              emit;
  logic              last_pix;
  logic [FA_W-1:0]   hm_next;
  logic [H_W-1:0]    row_idx;
  logic [W_W-1:0]    col_idx;
  logic [COL_W-1:0]  col_mux;

  logic [PIX_W-1:0]  lb_q [FILTER_L][IMG_W];

  assign accept   = pix.in_valid && ready_q;
  assign emit     = accept && (h_q >= H_EMIT);
  assign last_pix = (w_q == W_LAST) &&
                    (h_q == H_LAST);
  assign hm_next  = (hm_q == HM_LAST) ?
                    '0 : hm_q + 1'b1;
  assign row_idx  = h_q - H_EMIT;
  assign col_idx  = (w_q >= W_EMIT) ?
                    w_q - W_EMIT : '0;

  // Bank hm_q is about to be overwritten, so
  // its slot takes the incoming pixel instead.
  always_comb begin
    col_mux = '0;
    for (int b = 0; b < FILTER_L; b++) begin
      for (int i = 0; i < IMG_D; i++) begin
        col_mux[(i*FILTER_L+b)*DATA_WIDTH +:
                DATA_WIDTH] =
          (hm_q == FA_W'(b)) ?
          pix.in_data[i*DATA_WIDTH +:
                      DATA_WIDTH] :
          lb_q[b][w_q][i*DATA_WIDTH +:
                       DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL: begin
        if (accept && last_pix) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_val) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
    ready_d = (state_d == FILL);
    done_d  = (state_q == DRAIN) && last_val;
  end

  always_comb begin
    w_d  = w_q;
    h_d  = h_q;
    hm_d = hm_q;
    if (accept) begin
      if (w_q == W_LAST) begin
        w_d = '0;
        if (h_q == H_LAST) begin
          h_d  = '0;
          hm_d = '0;
        end else begin
          h_d  = h_q + 1'b1;
          hm_d = hm_next;
        end
      end else begin
        w_d = w_q + 1'b1;
      end
    end
  end

  always_comb begin
    col_d  = col_q;
    off_d  = off_q;
    addr_d = addr_q;
    wren_d = emit;
    if (accept) begin
      col_d = col_mux;
      off_d = hm_next;
    end
    // Warm-up columns land on the row's first
    // address and are overwritten in order.
    if (emit) begin
      addr_d = RA_W'(row_idx) *
               RA_W'(RESULT_W) +
               RA_W'(col_idx);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      ready_q <= 1'b0;
      w_q     <= '0;
      h_q     <= '0;
      hm_q    <= '0;
      col_q   <= '0;
      wren_q  <= 1'b0;
      off_q   <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      w_q     <= w_d;
      h_q     <= h_d;
      hm_q    <= hm_d;
      col_q   <= col_d;
      wren_q  <= wren_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb_q[hm_q][w_q] <= pix.in_data;
    end
  end

  assign pix.in_ready          = ready_q;
  assign img_data_in           = col_q;
  assign dpath_wren            = wren_q;
  assign dpath_sum_en          = wren_q;
  assign dpath_rotation_offset = off_q;
  assign dpath_result_wraddr   = addr_q;
  assign frame_done            = done_q;

endmodule

// File: tb/tb_conv_img_line_feeder.sv
// Directed bench for conv_img_line_feeder.
// 5x4 image, 2 channels, 3x3 filter.
module tb_conv_img_line_feeder;

  localparam int DW  = 8;
  localparam int IW  = 5;
  localparam int IH  = 4;
  localparam int ID  = 2;
  localparam int FL  = 3;
  localparam int COL = DW*ID*FL;

  logic             clk;
  logic             reset;
  logic [COL-1:0]   img_data_in;
  logic             dpath_wren;
  logic             dpath_sum_en;
  logic [1:0]       dpath_rotation_offset;
  logic [2:0]       dpath_result_wraddr;
  logic             last_val;
  logic             frame_done;

  int checks;
  int failures;

  conv_img_line_feeder_if #(
    .DATA_WIDTH(DW),
    .IMG_D(ID)
  ) pix ();

  conv_img_line_feeder #(
    .DATA_WIDTH(DW),
    .IMG_W(IW),
    .IMG_H(IH),
    .IMG_D(ID),
    .FILTER_L(FL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pix(pix),
    .img_data_in(img_data_in),
    .dpath_wren(dpath_wren),
    .dpath_sum_en(dpath_sum_en),
    .dpath_rotation_offset(dpath_rotation_offset),
    .dpath_result_wraddr(dpath_result_wraddr),
    .last_val(last_val),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [COL-1:0] exp_col(
    input int w, input int h);
    logic [COL-1:0] c;
    int row;
    c = '0;
    for (int ch = 0; ch < ID; ch++) begin
      for (int b = 0; b < FL; b++) begin
        row = h - 2;
        for (int r = h - 2; r <= h; r++) begin
          if (r % FL == b) row = r;
        end
        c[(ch*FL+b)*DW +: DW] =
          8'(ch*128 + row*16 + w);
      end
    end
    return c;
  endfunction

  function automatic logic [2:0] exp_addr(
    input int w, input int h);
    int c;
    c = (w >= 2) ? w - 2 : 0;
    return 3'((h - 2)*3 + c);
  endfunction

  task automatic drive_pix(input int w,
                           input int h);
    pix.in_data  = {8'(128 + h*16 + w),
                    8'(h*16 + w)};
    pix.in_valid = 1'b1;
  endtask

  task automatic run_frame(input bit toggle,
                           input int nrows,
                           input int nlast);
    logic [COL-1:0] ec;
    logic [2:0]     ea;
    logic [1:0]     eo;
    ea = dpath_result_wraddr;
    ec = img_data_in;
    for (int h = 0; h < nrows; h++) begin
      for (int w = 0; w < IW; w++) begin
        if (h == nrows - 1 && w >= nlast) break;
        drive_pix(w, h);
        @(posedge clk);
        #1;
        checks++;
        if (dpath_wren !== (h >= 2))
          $display("FAIL wren(%0d,%0d) got=%b exp=%b",
                   w, h, dpath_wren, (h >= 2));
        if (dpath_wren !== (h >= 2)) failures++;
        checks++;
        if (dpath_sum_en !== dpath_wren) begin
          $display("FAIL sum_en(%0d,%0d) got=%b exp=%b",
                   w, h, dpath_sum_en, dpath_wren);
          failures++;
        end
        ec = exp_col(w, h);
        eo = 2'((h + 1) % FL);
        if (h >= 2) begin
          ea = exp_addr(w, h);
          checks++;
          if (img_data_in !== ec) begin
            $display("FAIL col(%0d,%0d) got=%h exp=%h",
                     w, h, img_data_in, ec);
            failures++;
          end
          checks++;
          if (dpath_rotation_offset !== eo) begin
            $display("FAIL offset(%0d,%0d) got=%0d exp=%0d",
                     w, h, dpath_rotation_offset, eo);
            failures++;
          end
          checks++;
          if (dpath_result_wraddr !== ea) begin
            $display("FAIL addr(%0d,%0d) got=%0d exp=%0d",
                     w, h, dpath_result_wraddr, ea);
            failures++;
          end
        end
        if (toggle) begin
          pix.in_valid = 1'b0;
          @(posedge clk);
          #1;
          checks++;
          if (dpath_wren !== 1'b0) begin
            $display("FAIL bubble_wren(%0d,%0d) got=%b exp=0",
                     w, h, dpath_wren);
            failures++;
          end
          checks++;
          if (dpath_result_wraddr !== ea ||
              dpath_rotation_offset !== eo) begin
            $display("FAIL bubble_hold(%0d,%0d) got=%0d/%0d exp=%0d/%0d",
                     w, h, dpath_result_wraddr,
                     dpath_rotation_offset, ea, eo);
            failures++;
          end
        end
      end
    end
    pix.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset        = 1'b0;
    last_val     = 1'b0;
    pix.in_valid = 1'b1;
    pix.in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pix.in_ready !== 1'b0) begin
      $display("FAIL rst_ready got=%b exp=0",
               pix.in_ready);
      failures++;
    end
    checks++;
    if (img_data_in !== '0 ||
        dpath_wren !== 1'b0 ||
        dpath_sum_en !== 1'b0 ||
        dpath_rotation_offset !== '0 ||
        dpath_result_wraddr !== '0 ||
        frame_done !== 1'b0) begin
      $display("FAIL rst_outputs got=%h/%b/%b/%0d/%0d/%b exp=0",
               img_data_in, dpath_wren, dpath_sum_en,
               dpath_rotation_offset,
               dpath_result_wraddr, frame_done);
      failures++;
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (pix.in_ready !== 1'b1) begin
      $display("FAIL rst_release_ready got=%b exp=1",
               pix.in_ready);
      failures++;
    end
    checks++;
    if (dpath_wren !== 1'b0) begin
      $display("FAIL rst_release_wren got=%b exp=0",
               dpath_wren);
      failures++;
    end
    pix.in_valid = 1'b0;
  endtask

  task automatic test_fill_emit();
    run_frame(1'b0, IH, IW);
    checks++;
    if (pix.in_ready !== 1'b0) begin
      $display("FAIL last_pix_ready got=%b exp=0",
               pix.in_ready);
      failures++;
    end
  endtask

  task automatic test_drain();
    drive_pix(1, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (pix.in_ready !== 1'b0 ||
          dpath_wren !== 1'b0 ||
          frame_done !== 1'b0) begin
        $display("FAIL drain_hold[%0d] got=%b/%b/%b exp=0/0/0",
                 i, pix.in_ready, dpath_wren,
                 frame_done);
        failures++;
      end
    end
    pix.in_valid = 1'b0;
    last_val     = 1'b1;
    @(posedge clk);
    #1;
    last_val = 1'b0;
    checks++;
    if (frame_done !== 1'b1 ||
        pix.in_ready !== 1'b1) begin
      $display("FAIL drain_done got=%b/%b exp=1/1",
               frame_done, pix.in_ready);
      failures++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (frame_done !== 1'b0 ||
        pix.in_ready !== 1'b1) begin
      $display("FAIL drain_done_pulse got=%b/%b exp=0/1",
               frame_done, pix.in_ready);
      failures++;
    end
  endtask

  task automatic test_ignore_last_val();
    last_val = 1'b1;
    @(posedge clk);
    #1;
    last_val = 1'b0;
    checks++;
    if (frame_done !== 1'b0 ||
        pix.in_ready !== 1'b1) begin
      $display("FAIL fill_last_val got=%b/%b exp=0/1",
               frame_done, pix.in_ready);
      failures++;
    end
  endtask

  task automatic test_toggle();
    run_frame(1'b1, IH, IW);
    checks++;
    if (pix.in_ready !== 1'b0) begin
      $display("FAIL toggle_end_ready got=%b exp=0",
               pix.in_ready);
      failures++;
    end
    last_val = 1'b1;
    @(posedge clk);
    #1;
    last_val = 1'b0;
    checks++;
    if (frame_done !== 1'b1) begin
      $display("FAIL toggle_done got=%b exp=1",
               frame_done);
      failures++;
    end
  endtask

  task automatic test_mid_reset();
    run_frame(1'b0, 3, 3);
    reset = 1'b0;
    #1;
    checks++;
    if (pix.in_ready !== 1'b0 ||
        dpath_wren !== 1'b0 ||
        img_data_in !== '0 ||
        dpath_result_wraddr !== '0) begin
      $display("FAIL midrst_outputs got=%b/%b/%h/%0d exp=0",
               pix.in_ready, dpath_wren, img_data_in,
               dpath_result_wraddr);
      failures++;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (pix.in_ready !== 1'b1) begin
      $display("FAIL midrst_ready got=%b exp=1",
               pix.in_ready);
      failures++;
    end
    run_frame(1'b0, IH, IW);
    checks++;
    if (pix.in_ready !== 1'b0) begin
      $display("FAIL midrst_end_ready got=%b exp=0",
               pix.in_ready);
      failures++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_fill_emit();
    test_drain();
    test_ignore_last_val();
    test_toggle();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
